// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage load/store responder: each 32-bit access becomes two 16-bit SRAM half-accesses.
// Latency 2*(WAIT_STATES+1)+1 frozen cycles per access (ready low), then one DONE cycle with ready high.
module mem_stage_sram_ctrl #(
  parameter int BIT_NUMBER  = 32,
  parameter int SRAM_ADDR_W = 18,
  parameter int WAIT_STATES = 1,
  parameter int BASE_ADDR   = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [BIT_NUMBER-1:0]  alu_result,
  input  logic [BIT_NUMBER-1:0]  val_rm,
  output logic [BIT_NUMBER-1:0]  read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [2:0]             r_cnt;
  logic                   r_wr;
  logic [SRAM_ADDR_W-2:0] r_word;
  logic [BIT_NUMBER-1:0]  r_data;
  logic [15:0]            r_stage_lo;

  logic                   w_req;
  logic                   w_last;
  logic [BIT_NUMBER-1:0]  w_offs;

  assign w_req  = mem_r_en | mem_w_en;
  assign w_last = (r_cnt == 3'(WAIT_STATES));
  // Subtraction wraps mod 2^32; only the word bits that fit the SRAM are kept.
  assign w_offs = alu_result - BIT_NUMBER'(BASE_ADDR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req)  w_next = S_LO;
      S_LO:    if (w_last) w_next = S_HI;
      S_HI:    if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= 3'd0;
      r_wr       <= 1'b0;
      r_word     <= '0;
      r_data     <= '0;
      r_stage_lo <= 16'd0;
      read_data  <= '0;
    end else begin
      r_cnt <= (w_next != r_state) ? 3'd0 : r_cnt + 3'd1;
      if (r_state == S_IDLE && w_req) begin
        r_wr   <= mem_w_en;
        r_word <= w_offs[SRAM_ADDR_W:2];
        r_data <= val_rm;
      end
      // The high half goes straight into read_data so it is valid during DONE.
      if (!r_wr && w_last) begin
        if (r_state == S_LO) r_stage_lo <= sram_dq_in;
        if (r_state == S_HI) read_data  <= {sram_dq_in, r_stage_lo};
      end
    end
  end

  always_comb begin
    ready       = 1'b1;
    sram_addr   = '0;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (r_state)
      S_IDLE: ready = ~w_req;
      S_LO, S_HI: begin
        ready     = 1'b0;
        sram_addr = {r_word, (r_state == S_HI)};
        if (r_wr) begin
          sram_dq_oe  = 1'b1;
          sram_dq_out = (r_state == S_HI) ? r_data[31:16] : r_data[15:0];
          // Last cycle of the phase releases the strobe to hold address/data.
          sram_we_n   = w_last && (WAIT_STATES != 0);
        end
      end
      default: ready = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Scoreboard bench: two controllers (WAIT_STATES=1 and 0) each on a small SRAM model.
module tb_mem_stage_sram_ctrl;
  localparam int BASE = 1024;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        r_en  [2];
  logic        w_en  [2];
  logic [31:0] alu   [2];
  logic [31:0] rm    [2];

  logic [31:0] rdata0, rdata1;
  logic        rdy0, rdy1, oe0, oe1, wen0, wen1;
  logic [17:0] saddr0, saddr1;
  logic [15:0] dqo0, dqo1, dqi0, dqi1;

  mem_stage_sram_ctrl #(.WAIT_STATES(1)) u_dut0 (
    .clk(clk), .rst(rst_n[0]), .mem_r_en(r_en[0]), .mem_w_en(w_en[0]),
    .alu_result(alu[0]), .val_rm(rm[0]), .read_data(rdata0), .ready(rdy0),
    .sram_addr(saddr0), .sram_dq_out(dqo0), .sram_dq_in(dqi0),
    .sram_dq_oe(oe0), .sram_we_n(wen0));

  mem_stage_sram_ctrl #(.WAIT_STATES(0)) u_dut1 (
    .clk(clk), .rst(rst_n[1]), .mem_r_en(r_en[1]), .mem_w_en(w_en[1]),
    .alu_result(alu[1]), .val_rm(rm[1]), .read_data(rdata1), .ready(rdy1),
    .sram_addr(saddr1), .sram_dq_out(dqo1), .sram_dq_in(dqi1),
    .sram_dq_oe(oe1), .sram_we_n(wen1));

  // SRAM models: addresses used by the bench stay below 512 half-words.
  logic [15:0] smem0 [512];
  logic [15:0] smem1 [512];
  assign dqi0 = smem0[saddr0[8:0]];
  assign dqi1 = smem1[saddr1[8:0]];
  always @(posedge clk) begin
    if (wen0 === 1'b0) smem0[saddr0[8:0]] <= dqo0;
    if (wen1 === 1'b0) smem1[saddr1[8:0]] <= dqo1;
  end

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic [31:0] rd_exp;
    logic [17:0] a_lo;
  } txn_t;

  txn_t sb0[$];
  txn_t sb1[$];

  logic [15:0] rmem  [2][512];
  logic [31:0] mlast [2];

  int checks   = 0;
  int failures = 0;

  int          frozen   [2];
  int          nw       [2];
  int          lows     [2];
  logic        prev_low [2];
  logic [17:0] prev_ad  [2];
  logic [17:0] obs_a    [2][4];
  logic [15:0] obs_d    [2][4];
  logic [31:0] last_rd  [2];

  function automatic int ws(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%h expected=%h time=%0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic sb_push(input int k, input txn_t t);
    if (k == 0) sb0.push_back(t); else sb1.push_back(t);
  endtask

  function automatic int sb_size(input int k);
    return (k == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic txn_t sb_pop(input int k);
    if (k == 0) return sb0.pop_front();
    return sb1.pop_front();
  endfunction

  task automatic mon(input int k, input logic rs, input logic rd, input logic wn, input logic oe_,
                     input logic [17:0] ad, input logic [15:0] dout, input logic [31:0] rdat);
    txn_t t;
    if (!rs) begin
      frozen[k] = 0; nw[k] = 0; lows[k] = 0; prev_low[k] = 1'b0; last_rd[k] = 32'd0;
      if (k == 0) sb0.delete(); else sb1.delete();
      return;
    end
    if (!wn) begin
      chk("wr_oe", k, {31'd0, oe_}, 32'd1);
      if (!prev_low[k] || ad != prev_ad[k]) begin
        if (nw[k] < 4) begin
          obs_a[k][nw[k]] = ad;
          obs_d[k][nw[k]] = dout;
        end
        nw[k]++;
      end
      lows[k]++;
    end
    prev_low[k] = !wn;
    prev_ad[k]  = ad;
    if (!rd) begin
      frozen[k]++;
    end else if (frozen[k] == 0) begin
      chk("idle_we_n", k, {31'd0, wn}, 32'd1);
      chk("idle_oe", k, {31'd0, oe_}, 32'd0);
      chk("idle_rdata", k, rdat, last_rd[k]);
    end else begin
      if (sb_size(k) == 0) begin
        chk("unexpected_done", k, 32'd1, 32'd0);
      end else begin
        t = sb_pop(k);
        chk("freeze_len", k, frozen[k], 2 * (ws(k) + 1) + 1);
        chk("done_rdata", k, rdat, t.rd_exp);
        if (t.wr) begin
          chk("wr_halves", k, nw[k], 2);
          chk("wr_lows", k, lows[k], 2 * ((ws(k) == 0) ? 1 : ws(k)));
          if (nw[k] == 2) begin
            chk("wr_addr_lo", k, {14'd0, obs_a[k][0]}, {14'd0, t.a_lo});
            chk("wr_data_lo", k, {16'd0, obs_d[k][0]}, {16'd0, t.data[15:0]});
            chk("wr_addr_hi", k, {14'd0, obs_a[k][1]}, {14'd0, t.a_lo | 18'd1});
            chk("wr_data_hi", k, {16'd0, obs_d[k][1]}, {16'd0, t.data[31:16]});
          end
        end else begin
          chk("rd_no_write", k, nw[k], 0);
        end
        last_rd[k] = t.rd_exp;
      end
      frozen[k] = 0; nw[k] = 0; lows[k] = 0;
    end
  endtask

  always @(negedge clk) begin
    mon(0, rst_n[0], rdy0, wen0, oe0, saddr0, dqo0, rdata0);
    mon(1, rst_n[1], rdy1, wen1, oe1, saddr1, dqo1, rdata1);
  end

  // Reference model: word address from byte address, memory as half-word array.
  task automatic op(input int k, input bit rd_, input bit wr_, input logic [31:0] a,
                    input logic [31:0] d, input bit keep);
    txn_t        t;
    logic [31:0] word;
    logic [17:0] lo;
    logic [8:0]  idx;
    bit          seen0;
    bit          done;
    word = (a - 32'(BASE)) >> 2;
    lo   = {word[16:0], 1'b0};
    idx  = lo[8:0];
    if (wr_) begin
      rmem[k][idx]        = d[15:0];
      rmem[k][idx + 9'd1] = d[31:16];
    end else begin
      mlast[k] = {rmem[k][idx + 9'd1], rmem[k][idx]};
    end
    t.wr = wr_; t.data = d; t.rd_exp = mlast[k]; t.a_lo = lo;
    sb_push(k, t);
    r_en[k] = rd_; w_en[k] = wr_; alu[k] = a; rm[k] = d;
    seen0 = 0; done = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (((k == 0) ? rdy0 : rdy1) == 1'b0) seen0 = 1;
      else if (seen0) done = 1;
    end
    if (!done) chk("done_timeout", k, 32'd0, 32'd1);
    @(posedge clk); #1;
    if (!keep) begin
      r_en[k] = 1'b0; w_en[k] = 1'b0;
    end
  endtask

  task automatic rand_ops(input int k, input int n);
    int          mode;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      mode = $urandom_range(0, 2);
      a    = 32'(BASE) + 32'(4 * $urandom_range(0, 200)) + 32'($urandom_range(0, 3));
      op(k, mode != 1, mode != 0, a, $urandom, ($urandom_range(0, 1) == 1) && (i != n - 1));
      if (!w_en[k] && !r_en[k]) repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog inst=0 actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; r_en[k] = 1'b0; w_en[k] = 1'b0; alu[k] = 32'd0; rm[k] = 32'd0;
      mlast[k] = 32'd0; last_rd[k] = 32'd0; frozen[k] = 0; nw[k] = 0; lows[k] = 0;
      prev_low[k] = 1'b0; prev_ad[k] = 18'd0;
      for (int i = 0; i < 512; i++) rmem[k][i] = 16'd0;
    end
    for (int i = 0; i < 512; i++) begin
      smem0[i] = 16'd0; smem1[i] = 16'd0;
    end
    repeat (3) @(posedge clk); #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(negedge clk);
    chk("rst_ready", 0, {31'd0, rdy0}, 32'd1);
    chk("rst_we_n", 0, {31'd0, wen0}, 32'd1);
    chk("rst_oe", 0, {31'd0, oe0}, 32'd0);
    chk("rst_rdata", 0, rdata0, 32'd0);
    chk("rst_addr", 0, {14'd0, saddr0}, 32'd0);
    chk("rst_ready", 1, {31'd0, rdy1}, 32'd1);
    chk("rst_rdata", 1, rdata1, 32'd0);
    @(posedge clk); #1;

    // Directed cases on the WAIT_STATES=1 instance.
    op(0, 0, 1, 32'd1032, 32'hDEADBEEF, 0);
    op(0, 1, 0, 32'd1032, 32'd0, 0);
    repeat (3) @(posedge clk); #1;
    op(0, 1, 1, 32'd1024, 32'h12345678, 0);
    op(0, 0, 1, 32'd1064, 32'hCAFEF00D, 0);
    op(0, 1, 0, 32'd1064, 32'd0, 0);

    // Abort a load in its HI phase with reset.
    r_en[0] = 1'b1; alu[0] = 32'd1064;
    repeat (3) @(posedge clk); #1;
    chk("hi_addr", 0, {14'd0, saddr0}, 32'd21);
    rst_n[0] = 1'b0; r_en[0] = 1'b0;
    #1;
    chk("abort_rdata", 0, rdata0, 32'd0);
    chk("abort_we_n", 0, {31'd0, wen0}, 32'd1);
    chk("abort_oe", 0, {31'd0, oe0}, 32'd0);
    chk("abort_addr", 0, {14'd0, saddr0}, 32'd0);
    chk("abort_ready", 0, {31'd0, rdy0}, 32'd1);
    mlast[0] = 32'd0;
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    @(posedge clk); #1;
    op(0, 1, 0, 32'd1064, 32'd0, 0);
    rand_ops(0, 40);

    // Back-to-back stores with the request held through DONE, WAIT_STATES=0.
    op(1, 0, 1, 32'd1032, 32'hAAAA5555, 1);
    op(1, 0, 1, 32'd1036, 32'h0BADC0DE, 1);
    op(1, 0, 1, 32'd1040, 32'h600DF00D, 0);
    op(1, 1, 0, 32'd1032, 32'd0, 0);
    op(1, 1, 0, 32'd1036, 32'd0, 1);
    op(1, 1, 0, 32'd1040, 32'd0, 0);
    rand_ops(1, 40);

    r_en[0] = 1'b0; w_en[0] = 1'b0; r_en[1] = 1'b0; w_en[1] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sb_drain", 0, sb_size(0), 0);
    chk("sb_drain", 1, sb_size(1), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- Memory-stage responder for the load/store requests issued by the EXE stage.
- Takes the ALU result as byte address and the forwarded Rm value as store data.
- Performs each 32-bit word access as two 16-bit half-accesses on an external single-port SRAM, with programmable wait states.
- Drives `ready` low to freeze the pipeline until the access completes.

Parameters:
- BIT_NUMBER, 32: CPU data/address width.
- SRAM_ADDR_W, 18: SRAM half-word address width.
- WAIT_STATES, 1: extra cycles each half-access is held (0..7).
- BASE_ADDR, 1024: byte offset subtracted from the CPU address before mapping.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- mem_r_en  in  1  load request from EXE/MEM register.
- mem_w_en  in  1  store request from EXE/MEM register.
- alu_result  in  32  byte address.
- val_rm  in  32  store data.
- read_data  out  32  load result.
- ready  out  1  high = no access pending; low = freeze pipeline.
- sram_addr  out  SRAM_ADDR_W  half-word address.
- sram_dq_out  out  16  write data to SRAM.
- sram_dq_in  in  16  read data from SRAM.
- sram_dq_oe  out  1  controller drives the data bus.
- sram_we_n  out  1  active-low write strobe.

Behaviour:
- Reset (rst=0, async), all outputs:
  - state=IDLE.
  - read_data=0, sram_addr=0, sram_dq_out=0.
  - sram_dq_oe=0, sram_we_n=1.
  - Latched op/address/data cleared.
  - Reset mid-access aborts immediately; no partial read_data update.
- Address mapping: word = (alu_result - BASE_ADDR) >> 2, computed mod 2^32. Low half uses sram_addr = {word[SRAM_ADDR_W-2:0],0}; high half uses {word[SRAM_ADDR_W-2:0],1}. Upper word bits are discarded (wrap-around, no error).
- States: IDLE -> LO -> HI -> DONE -> IDLE.
- IDLE:
  - If mem_w_en|mem_r_en, latch op, mapped address and val_rm, then go to LO.
  - If both requests are high, the op is a write.
  - ready = ~(mem_r_en|mem_w_en), combinational, so the request cycle itself is frozen.
- LO and HI:
  - Each lasts WAIT_STATES+1 cycles, timed by a 3-bit counter cleared on entry.
  - sram_addr holds the half address for the whole phase.
  - Write: sram_dq_oe=1 and sram_dq_out = data[15:0] (LO) or data[31:16] (HI). sram_we_n=0 in every cycle of the phase except the last, where it is 1 (address/data hold). When WAIT_STATES=0, sram_we_n=0 for the single cycle.
  - Read: sram_dq_oe=0, sram_we_n=1. sram_dq_in is sampled on the last cycle of the phase into a staging register (LO -> bits 15:0, HI -> bits 31:16).
  - ready=0 throughout.
- DONE (1 cycle):
  - ready=1.
  - For a read, read_data is updated from the staging register on DONE entry, so it is valid while ready=1.
  - Go to IDLE unconditionally. The still-asserted request is not restarted in DONE. In the following IDLE cycle it is treated as a new instruction's request.
- read_data holds its value until the next read completes; writes never change it.
- Freeze length per access = 2*(WAIT_STATES+1)+1 cycles of ready=0, including the IDLE request cycle. With default WAIT_STATES=1 this is 5 cycles, and ready=1 on the 6th.
- No request while in IDLE: ready=1 and the SRAM stays idle (oe=0, we_n=1).

Test Plan:
- Reset, then idle with no request: ready=1, sram_we_n=1, sram_dq_oe=0, read_data=0.
- Store, WAIT_STATES=1, mem_w_en=1, alu_result=1032, val_rm=0xDEADBEEF:
  - sram_addr=4 with dq_out=0xBEEF, then sram_addr=5 with dq_out=0xDEAD.
  - we_n low for 1 cycle per half.
  - ready low 5 cycles, then high 1 cycle.
- Load of the same address with the SRAM model returning the stored halves: read_data=0xDEADBEEF in the DONE cycle (ready=1); unchanged afterwards.
- mem_r_en=mem_w_en=1, alu_result=1024, val_rm=0x12345678: a write occurs (halves 0x5678/0x1234 at addresses 0/1); read_data unchanged.
- Assert rst=0 during the HI phase of a load following a prior read of 0xCAFEF00D: outputs return immediately to reset values (read_data=0). The next request starts cleanly from IDLE.
- WAIT_STATES=0, back-to-back stores held high across DONE: each store takes exactly 3 frozen cycles plus 1 DONE. The second store begins in the IDLE cycle after DONE. No duplicate write of the first.
